// File: rtl/snake_dir_input_if.sv
// Button, strobe and heading signals between the snake core side and the
// direction conditioner.
interface snake_dir_input_if;
  logic       BtnL;
  logic       BtnR;
  logic       BtnU;
  logic       BtnD;
  logic       Tick;
  logic       Init;
  logic       Left;
  logic       Right;
  logic       Up;
  logic       Down;
  logic [1:0] Dir;
  logic       Changed;

  modport master (
    output BtnL, BtnR, BtnU, BtnD, Tick, Init,
    input  Left, Right, Up, Down, Dir, Changed
  );

  modport slave (
    input  BtnL, BtnR, BtnU, BtnD, Tick, Init,
    output Left, Right, Up, Down, Dir, Changed
  );
endinterface

// File: rtl/snake_dir_input.sv
// Direction conditioner: synchronises and debounces four buttons, rejects
// reversals and holds one turn request until the core's next move step.
module snake_dir_input #(
  parameter int DB_COUNT = 500000,
  parameter int CNT_W    = 20
) (
  input  logic             Clk,
  input  logic             Reset,
  snake_dir_input_if.slave bus
);

  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_U = 2'b10;
  localparam logic [1:0] DIR_D = 2'b11;

  localparam logic [1:0] ST_STABLE0 = 2'd0;
  localparam logic [1:0] ST_WAIT1   = 2'd1;
  localparam logic [1:0] ST_STABLE1 = 2'd2;
  localparam logic [1:0] ST_WAIT0   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  // Button vectors are indexed 0=L, 1=R, 2=U, 3=D throughout.
  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [1:0]       db_state [4];
  logic [CNT_W-1:0] db_cnt   [4];
  logic [3:0]       press;

  logic       sel_valid;
  logic [1:0] sel_dir;

  logic [1:0] heading;
  logic [3:0] onehot;
  logic       changed;
  logic       pend_valid;
  logic [1:0] pend_dir;

  logic [1:0] heading_nxt;
  logic [3:0] onehot_nxt;
  logic       changed_nxt;
  logic       pend_valid_nxt;
  logic [1:0] pend_dir_nxt;

  assign raw = {bus.BtnD, bus.BtnU, bus.BtnR, bus.BtnL};

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Counter restarts on entry to each WAIT state and stops at CNT_LAST, so it cannot wrap.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        db_state[i] <= ST_STABLE0;
        db_cnt[i]   <= '0;
      end
      press <= '0;
    end else begin
      press <= '0;
      for (int i = 0; i < 4; i++) begin
        case (db_state[i])
          ST_STABLE0: begin
            if (sync2[i]) begin
              db_state[i] <= ST_WAIT1;
              db_cnt[i]   <= '0;
            end
          end
          ST_WAIT1: begin
            if (!sync2[i]) begin
              db_state[i] <= ST_STABLE0;
            end else if (db_cnt[i] == CNT_LAST) begin
              db_state[i] <= ST_STABLE1;
              press[i]    <= 1'b1;
            end else begin
              db_cnt[i] <= db_cnt[i] + 1'b1;
            end
          end
          ST_STABLE1: begin
            if (!sync2[i]) begin
              db_state[i] <= ST_WAIT0;
              db_cnt[i]   <= '0;
            end
          end
          default: begin
            if (sync2[i]) begin
              db_state[i] <= ST_STABLE1;
            end else if (db_cnt[i] == CNT_LAST) begin
              db_state[i] <= ST_STABLE0;
            end else begin
              db_cnt[i] <= db_cnt[i] + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b1;
    sel_dir   = DIR_L;
    if (press[0])      sel_dir = DIR_L;
    else if (press[1]) sel_dir = DIR_R;
    else if (press[2]) sel_dir = DIR_U;
    else if (press[3]) sel_dir = DIR_D;
    else               sel_valid = 1'b0;
  end

  // The press is judged against the heading that will hold after this edge;
  // with this encoding the opposite heading is the low bit inverted.
  always_comb begin
    heading_nxt    = heading;
    pend_valid_nxt = pend_valid;
    pend_dir_nxt   = pend_dir;
    changed_nxt    = 1'b0;
    if (bus.Init) begin
      heading_nxt    = DIR_R;
      pend_valid_nxt = 1'b0;
    end else begin
      if (bus.Tick && pend_valid) begin
        heading_nxt    = pend_dir;
        pend_valid_nxt = 1'b0;
        changed_nxt    = 1'b1;
      end
      if (sel_valid && (sel_dir != heading_nxt) &&
          (sel_dir != (heading_nxt ^ 2'b01))) begin
        pend_valid_nxt = 1'b1;
        pend_dir_nxt   = sel_dir;
      end
    end
    onehot_nxt = 4'b0001 << heading_nxt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      heading    <= DIR_R;
      onehot     <= 4'b0010;
      changed    <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= DIR_L;
    end else begin
      heading    <= heading_nxt;
      onehot     <= onehot_nxt;
      changed    <= changed_nxt;
      pend_valid <= pend_valid_nxt;
      pend_dir   <= pend_dir_nxt;
    end
  end

  assign bus.Left    = onehot[0];
  assign bus.Right   = onehot[1];
  assign bus.Up      = onehot[2];
  assign bus.Down    = onehot[3];
  assign bus.Dir     = heading;
  assign bus.Changed = changed;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with DB_COUNT=4: debounce, reversal
// rejection, latest-wins pending, arbitration and Init override.
module tb_snake_dir_input;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  snake_dir_input_if bus ();

  snake_dir_input #(.DB_COUNT(4), .CNT_W(3)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-hot view ordered {Down, Up, Right, Left}.
  localparam logic [3:0] OH_L = 4'b0001;
  localparam logic [3:0] OH_R = 4'b0010;
  localparam logic [3:0] OH_U = 4'b0100;
  localparam logic [3:0] OH_D = 4'b1000;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [1:0] dir,
                             input logic [3:0] oh, input logic chg);
    check({tag, ".dir"}, {2'b00, bus.Dir}, {2'b00, dir});
    check({tag, ".onehot"}, {bus.Down, bus.Up, bus.Right, bus.Left}, oh);
    check({tag, ".changed"}, {3'b000, bus.Changed}, {3'b000, chg});
  endtask

  // Called at a negedge; returns at a negedge after the buttons have settled.
  task automatic hold_btns(input logic [3:0] m, input int n);
    {bus.BtnD, bus.BtnU, bus.BtnR, bus.BtnL} = m;
    repeat (n) @(negedge clk);
    {bus.BtnD, bus.BtnU, bus.BtnR, bus.BtnL} = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  task automatic tick_pulse();
    bus.Tick = 1'b1;
    @(negedge clk);
    bus.Tick = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    {bus.BtnD, bus.BtnU, bus.BtnR, bus.BtnL} = 4'b0000;
    bus.Tick = 1'b0;
    bus.Init = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset", 2'b01, OH_R, 1'b0);

    rst = 1'b0;
    @(negedge clk);

    // Reset asserted while BtnU is part-way through its debounce window.
    bus.BtnU = 1'b1;
    repeat (4) @(negedge clk);
    rst      = 1'b1;
    bus.BtnU = 1'b0;
    #2;
    check("mid_reset.dir", {2'b00, bus.Dir}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tick_pulse();
    check_state("after_mid_reset", 2'b01, OH_R, 1'b0);

    // Three-cycle glitch is too short to count as a press.
    hold_btns(4'b0100, 3);
    tick_pulse();
    check_state("glitch", 2'b01, OH_R, 1'b0);

    // LEFT from RIGHT is a reversal.
    hold_btns(4'b0001, 10);
    tick_pulse();
    check_state("reversal", 2'b01, OH_R, 1'b0);

    // Valid UP press is held until the Tick.
    hold_btns(4'b0100, 10);
    check_state("up_pending", 2'b01, OH_R, 1'b0);
    tick_pulse();
    check_state("up_commit", 2'b10, OH_U, 1'b1);
    @(negedge clk);
    check_state("up_settled", 2'b10, OH_U, 1'b0);

    // L and U together from UP: L has priority.
    hold_btns(4'b0101, 10);
    tick_pulse();
    check_state("arb_lu", 2'b00, OH_L, 1'b1);

    // U and D together from LEFT: U has priority over D.
    hold_btns(4'b1100, 10);
    tick_pulse();
    check_state("arb_ud", 2'b10, OH_U, 1'b1);

    // Init alone forces RIGHT.
    bus.Init = 1'b1;
    @(negedge clk);
    bus.Init = 1'b0;
    check_state("init", 2'b01, OH_R, 1'b0);

    // UP then DOWN both accepted before the Tick: latest wins.
    hold_btns(4'b0100, 10);
    hold_btns(4'b1000, 10);
    tick_pulse();
    check_state("latest_wins", 2'b11, OH_D, 1'b1);

    // Pending LEFT from DOWN is dropped by Init, which beats a same-cycle Tick.
    hold_btns(4'b0001, 10);
    bus.Init = 1'b1;
    bus.Tick = 1'b1;
    @(negedge clk);
    bus.Init = 1'b0;
    bus.Tick = 1'b0;
    check_state("init_over_tick", 2'b01, OH_R, 1'b0);
    @(negedge clk);
    tick_pulse();
    check_state("pending_cleared", 2'b01, OH_R, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
